// File: rtl/cmd_pkg.sv
// Opcodes and FSM state encoding shared by the command stream decoder.
// state      | meaning
// S_OP       | waiting for / decoding an opcode byte
// S_TRI      | shifting triangle payload bytes
// S_TEX_AH   | expecting texture address high byte
// S_TEX_AL   | expecting texture address low byte
// S_TEX_LEN  | expecting texture word count (0 = 256)
// S_TEX_DATA | assembling texture words
// S_REG_A    | expecting register address
// S_REG_D    | expecting register data
// S_PUSH     | holding a completed triangle until the vertex FIFO accepts it
package cmd_pkg;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_TRI = 8'h01;
  localparam logic [7:0] OP_TEX = 8'h02;
  localparam logic [7:0] OP_REG = 8'h03;

  typedef enum logic [3:0] {
    S_OP,
    S_TRI,
    S_TEX_AH,
    S_TEX_AL,
    S_TEX_LEN,
    S_TEX_DATA,
    S_REG_A,
    S_REG_D,
    S_PUSH
  } state_t;

endpackage

// File: rtl/cmd_byte_shifter.sv
// Byte-wide shift-in register; last_o flags that the byte loaded now completes a WIDTH-bit word.
module cmd_byte_shifter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [7:0]       byte_i,
  output logic [WIDTH-1:0] data_o,
  output logic             last_o
);

  localparam int NBYTES = WIDTH / 8;
  localparam logic [7:0] LAST_IDX = 8'(NBYTES - 1);

  logic [WIDTH-1:0] data_q;
  logic [7:0]       cnt_q;

  assign last_o = (cnt_q == LAST_IDX);
  assign data_o = data_q;

  // Earliest byte ends up in the MSBs once the word is complete.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      data_q <= WIDTH'({data_q, byte_i});
      cnt_q  <= last_o ? 8'd0 : cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/command_stream_decoder.sv
// Opcode-framed byte stream decoder feeding vertex FIFO, texture RAM and control registers.
// Define CMD_STATS_EN to add the stat_tri_cnt / stat_tex_cnt counters.
module command_stream_decoder
  import cmd_pkg::*;
#(
  parameter int TRI_BYTES = 60,
  parameter int TEX_W     = 16,
  parameter int TEX_AW    = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             command_rddata,
  output logic                   command_pull,
  input  logic                   command_empty,
  input  logic                   triangle_full,
  output logic [TRI_BYTES*8-1:0] triangle_wrdata,
  output logic                   triangle_push,
  output logic [TEX_AW-1:0]      tex_wraddr,
  output logic [TEX_W-1:0]       tex_wrdata,
  output logic                   tex_we,
  output logic [7:0]             reg_wraddr,
  output logic [7:0]             reg_wrdata,
  output logic                   reg_we,
  output logic                   cmd_error,
`ifdef CMD_STATS_EN
  output logic [15:0]            stat_tri_cnt,
  output logic [15:0]            stat_tex_cnt,
`endif
  output logic                   idle
);

  state_t            state_q, state_d;
  logic              inflight_q;
  logic [7:0]        addr_hi_q;
  logic [TEX_AW-1:0] tex_addr_q;
  logic [7:0]        len_q;
  logic              tex_we_q;
  logic [7:0]        reg_addr_q;
  logic [7:0]        reg_data_q;
  logic              reg_we_q;
  logic              err_q;

  logic last_byte, stall, push, err_set;
  logic tri_load, tri_last, tex_load, tex_last;

  assign tri_load = inflight_q && (state_q == S_TRI);
  assign tex_load = inflight_q && (state_q == S_TEX_DATA);

  cmd_byte_shifter #(.WIDTH(TRI_BYTES*8)) u_tri_shift (
    .clk    (clk),
    .rst    (rst),
    .load_i (tri_load),
    .byte_i (command_rddata),
    .data_o (triangle_wrdata),
    .last_o (tri_last)
  );

  cmd_byte_shifter #(.WIDTH(TEX_W)) u_tex_shift (
    .clk    (clk),
    .rst    (rst),
    .load_i (tex_load),
    .byte_i (command_rddata),
    .data_o (tex_wrdata),
    .last_o (tex_last)
  );

  always_comb begin
    state_d   = state_q;
    last_byte = 1'b0;
    stall     = 1'b0;
    push      = 1'b0;
    err_set   = 1'b0;
    case (state_q)
      S_OP: if (inflight_q) begin
        if (command_rddata == OP_TRI)      state_d = S_TRI;
        else if (command_rddata == OP_TEX) state_d = S_TEX_AH;
        else if (command_rddata == OP_REG) state_d = S_REG_A;
        else begin
          last_byte = 1'b1;
          err_set   = (command_rddata != OP_NOP);
        end
      end
      S_TRI: if (inflight_q && tri_last) begin
        last_byte = 1'b1;
        state_d   = S_PUSH;
      end
      S_TEX_AH:  if (inflight_q) state_d = S_TEX_AL;
      S_TEX_AL:  if (inflight_q) state_d = S_TEX_LEN;
      S_TEX_LEN: if (inflight_q) state_d = S_TEX_DATA;
      S_TEX_DATA: if (inflight_q && tex_last && (len_q == 8'd1)) begin
        last_byte = 1'b1;
        state_d   = S_OP;
      end
      S_REG_A: if (inflight_q) state_d = S_REG_D;
      S_REG_D: if (inflight_q) begin
        last_byte = 1'b1;
        state_d   = S_OP;
      end
      S_PUSH: begin
        stall = 1'b1;
        if (!triangle_full) begin
          push    = 1'b1;
          state_d = S_OP;
        end
      end
      default: state_d = S_OP;
    endcase
  end

  // Never pull past the end of a packet: the next opcode must be decoded first.
  assign command_pull = !command_empty && !stall && !last_byte;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_OP;
      inflight_q <= 1'b0;
      addr_hi_q  <= '0;
      tex_addr_q <= '0;
      len_q      <= '0;
      tex_we_q   <= 1'b0;
      reg_addr_q <= '0;
      reg_data_q <= '0;
      reg_we_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= command_pull;
      err_q      <= err_q | err_set;
      tex_we_q   <= tex_load && tex_last;
      reg_we_q   <= inflight_q && (state_q == S_REG_D);
      if (inflight_q && (state_q == S_TEX_AH)) addr_hi_q <= command_rddata;
      if (inflight_q && (state_q == S_TEX_AL)) tex_addr_q <= TEX_AW'({addr_hi_q, command_rddata});
      else if (tex_we_q) tex_addr_q <= tex_addr_q + TEX_AW'(1);
      if (inflight_q && (state_q == S_TEX_LEN)) len_q <= command_rddata;
      else if (tex_load && tex_last) len_q <= len_q - 8'd1;
      if (inflight_q && (state_q == S_REG_A)) reg_addr_q <= command_rddata;
      if (inflight_q && (state_q == S_REG_D)) reg_data_q <= command_rddata;
    end
  end

  assign triangle_push = push;
  assign tex_wraddr    = tex_addr_q;
  assign tex_we        = tex_we_q;
  assign reg_wraddr    = reg_addr_q;
  assign reg_wrdata    = reg_data_q;
  assign reg_we        = reg_we_q;
  assign cmd_error     = err_q;
  assign idle          = (state_q == S_OP) && !inflight_q;

`ifdef CMD_STATS_EN
  logic [15:0] stat_tri_q, stat_tex_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_tri_q <= '0;
      stat_tex_q <= '0;
    end else begin
      if (push)     stat_tri_q <= stat_tri_q + 16'd1;
      if (tex_we_q) stat_tex_q <= stat_tex_q + 16'd1;
    end
  end

  assign stat_tri_cnt = stat_tri_q;
  assign stat_tex_cnt = stat_tex_q;
`endif

endmodule

// File: tb/tb_command_stream_decoder.sv
// Self-checking bench: byte-queue FIFO model, packet-level reference parser, scoreboarded strobes.
module tb_command_stream_decoder;

  localparam int TRI_BYTES = 4;
  localparam int TEX_W     = 16;
  localparam int TEX_AW    = 14;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [7:0]             command_rddata;
  logic                   command_pull;
  logic                   command_empty;
  logic                   triangle_full;
  logic [TRI_BYTES*8-1:0] triangle_wrdata;
  logic                   triangle_push;
  logic [TEX_AW-1:0]      tex_wraddr;
  logic [TEX_W-1:0]       tex_wrdata;
  logic                   tex_we;
  logic [7:0]             reg_wraddr;
  logic [7:0]             reg_wrdata;
  logic                   reg_we;
  logic                   cmd_error;
  logic                   idle;

  always #5 clk = ~clk;

  command_stream_decoder #(
    .TRI_BYTES (TRI_BYTES),
    .TEX_W     (TEX_W),
    .TEX_AW    (TEX_AW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .command_rddata  (command_rddata),
    .command_pull    (command_pull),
    .command_empty   (command_empty),
    .triangle_full   (triangle_full),
    .triangle_wrdata (triangle_wrdata),
    .triangle_push   (triangle_push),
    .tex_wraddr      (tex_wraddr),
    .tex_wrdata      (tex_wrdata),
    .tex_we          (tex_we),
    .reg_wraddr      (reg_wraddr),
    .reg_wrdata      (reg_wrdata),
    .reg_we          (reg_we),
    .cmd_error       (cmd_error),
    .idle            (idle)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0]  fifo[$];
  logic [7:0]  stream[$];
  logic [31:0] exp_tri[$];
  int          exp_tex_a[$];
  int          exp_tex_d[$];
  logic [15:0] exp_reg[$];
  logic        exp_err;
  logic [7:0]  last_ra, last_rd;

  logic        gap_en, full_rand, full_force;
  logic        pulled;
  logic [7:0]  next_byte;
  int          pull_count;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: parse a whole byte stream into the writes it must cause.
  task automatic model_and_load();
    int i, n, addr, d;
    longint v;
    logic [7:0] op;
    i = 0;
    while (i < stream.size()) begin
      op = stream[i];
      i++;
      case (op)
        8'h00: ;
        8'h01: begin
          v = 0;
          for (int k = 0; k < TRI_BYTES; k++) begin
            v = v * 256 + longint'(stream[i]);
            i++;
          end
          exp_tri.push_back(32'(v));
        end
        8'h02: begin
          addr = (int'(stream[i]) * 256 + int'(stream[i+1])) % (1 << TEX_AW);
          n = (stream[i+2] == 8'd0) ? 256 : int'(stream[i+2]);
          i += 3;
          for (int w = 0; w < n; w++) begin
            d = 0;
            for (int b = 0; b < TEX_W / 8; b++) begin
              d = d * 256 + int'(stream[i]);
              i++;
            end
            exp_tex_a.push_back(addr);
            exp_tex_d.push_back(d);
            addr = (addr + 1) % (1 << TEX_AW);
          end
        end
        8'h03: begin
          exp_reg.push_back({stream[i], stream[i+1]});
          last_ra = stream[i];
          last_rd = stream[i+1];
          i += 2;
        end
        default: exp_err = 1'b1;
      endcase
    end
    foreach (stream[j]) fifo.push_back(stream[j]);
    stream.delete();
  endtask

  task automatic cycle();
    @(negedge clk);
    command_rddata = pulled ? next_byte : 8'($urandom);
    command_empty  = (fifo.size() == 0) || (gap_en && $urandom_range(0, 3) == 0);
    triangle_full  = full_force || (full_rand && $urandom_range(0, 2) == 0);
    #1;
    if (triangle_push) begin
      check_val("push_while_full", triangle_full, 0);
      if (exp_tri.size() == 0) check_val("tri_unexpected", triangle_push, 0);
      else check_val("tri_data", triangle_wrdata, exp_tri.pop_front());
    end
    if (tex_we) begin
      if (exp_tex_a.size() == 0) check_val("tex_unexpected", tex_we, 0);
      else begin
        check_val("tex_addr", tex_wraddr, exp_tex_a.pop_front());
        check_val("tex_data", tex_wrdata, exp_tex_d.pop_front());
      end
    end
    if (reg_we) begin
      if (exp_reg.size() == 0) check_val("reg_unexpected", reg_we, 0);
      else check_val("reg_write", {reg_wraddr, reg_wrdata}, exp_reg.pop_front());
    end
    if (tex_we || reg_we) check_val("we_overlap", tex_we & reg_we, 0);
    pulled = command_pull;
    if (command_pull) begin
      if (command_empty) check_val("pull_while_empty", command_pull, 0);
      else begin
        next_byte = fifo.pop_front();
        pull_count++;
      end
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((fifo.size() != 0 || !idle) && n < budget) begin
      cycle();
      n++;
    end
    repeat (4) cycle();
    check_val("drain_timeout", n < budget, 1);
    check_val("tri_left", exp_tri.size(), 0);
    check_val("tex_left", exp_tex_a.size(), 0);
    check_val("reg_left", exp_reg.size(), 0);
    check_val("cmd_error", cmd_error, exp_err);
    check_val("idle", idle, 1);
    check_val("reg_hold", {reg_wraddr, reg_wrdata}, {last_ra, last_rd});
  endtask

  task automatic push_bytes(input logic [7:0] b[$]);
    foreach (b[j]) stream.push_back(b[j]);
  endtask

  task automatic add_random_packet(input logic allow_bad);
    int k, len;
    k = $urandom_range(0, allow_bad ? 4 : 3);
    case (k)
      0: stream.push_back(8'h00);
      1: begin
        stream.push_back(8'h01);
        repeat (TRI_BYTES) stream.push_back(8'($urandom));
      end
      2: begin
        len = $urandom_range(1, 4);
        stream.push_back(8'h02);
        stream.push_back(8'($urandom));
        stream.push_back(8'($urandom));
        stream.push_back(8'(len));
        repeat (len * TEX_W / 8) stream.push_back(8'($urandom));
      end
      3: begin
        stream.push_back(8'h03);
        stream.push_back(8'($urandom));
        stream.push_back(8'($urandom));
      end
      default: stream.push_back(8'($urandom_range(4, 255)));
    endcase
  endtask

  initial begin
    int n;
    rst = 1'b1;
    command_rddata = 8'h00;
    command_empty = 1'b1;
    triangle_full = 1'b0;
    gap_en = 1'b0; full_rand = 1'b0; full_force = 1'b0;
    pulled = 1'b0; next_byte = 8'h00; pull_count = 0;
    exp_err = 1'b0; last_ra = 8'h00; last_rd = 8'h00;

    repeat (2) cycle();
    check_val("rst_push", triangle_push, 0);
    check_val("rst_tex_we", tex_we, 0);
    check_val("rst_reg_we", reg_we, 0);
    check_val("rst_err", cmd_error, 0);
    check_val("rst_idle", idle, 1);
    check_val("rst_pull", command_pull, 0);
    check_val("rst_tri_data", triangle_wrdata, 0);
    check_val("rst_tex_addr", tex_wraddr, 0);
    rst = 1'b0;

    // Single triangle
    push_bytes('{8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD});
    model_and_load();
    drain(200);

    // Vertex FIFO full at packet end, next packet already queued
    full_force = 1'b1;
    n = pull_count;
    push_bytes('{8'h01, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h00});
    model_and_load();
    while (pull_count < n + 5 && pull_count < n + 100) cycle();
    repeat (10) begin
      cycle();
      check_val("pull_during_full", command_pull, 0);
      check_val("push_during_full", triangle_push, 0);
    end
    full_force = 1'b0;
    drain(200);

    // Texture with address wrap
    push_bytes('{8'h02, 8'h3F, 8'hFF, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78});
    model_and_load();
    drain(200);

    // Register write
    push_bytes('{8'h03, 8'h05, 8'hA5});
    model_and_load();
    drain(200);

    // Unknown opcode then NOP then register write
    push_bytes('{8'h7E, 8'h00, 8'h03, 8'h01, 8'h02});
    model_and_load();
    drain(200);

    // Texture with LEN=0 (256 words)
    stream.push_back(8'h02); stream.push_back(8'h10); stream.push_back(8'h00); stream.push_back(8'h00);
    repeat (256 * TEX_W / 8) stream.push_back(8'($urandom));
    model_and_load();
    drain(2000);

    // Reset part way through a triangle
    fifo.push_back(8'h01); fifo.push_back(8'h11); fifo.push_back(8'h22);
    n = 0;
    while (fifo.size() != 0 && n < 100) begin cycle(); n++; end
    repeat (3) cycle();
    check_val("mid_tri_idle", idle, 0);
    rst = 1'b1;
    exp_err = 1'b0; last_ra = 8'h00; last_rd = 8'h00;
    repeat (2) cycle();
    check_val("rst_mid_err", cmd_error, 0);
    rst = 1'b0;
    push_bytes('{8'h01, 8'h5A, 8'h6B, 8'h7C, 8'h8D});
    model_and_load();
    drain(200);

    // Randomised streams with FIFO gaps and vertex FIFO back-pressure
    for (int it = 0; it < 40; it++) begin
      gap_en = 1'($urandom_range(0, 1));
      full_rand = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 5)) add_random_packet(it >= 30);
      model_and_load();
      drain(3000);
    end
    gap_en = 1'b0; full_rand = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
